// File: rtl/vpu_sprite_pkg.sv
// Shared definitions for the sprite line scanner: default sizes, the empty
// table entry, the scanner state encoding and index-width helpers.
package vpu_sprite_pkg;

  localparam int ENTRY_W_DEF      = 18;
  localparam int NUM_SPRITES_DEF  = 32;
  localparam int MAX_PER_LINE_DEF = 4;
  localparam int ADDR_W_DEF       = $clog2(NUM_SPRITES_DEF);
  localparam int CNT_W_DEF        = $clog2(MAX_PER_LINE_DEF + 1);

  localparam logic [ENTRY_W_DEF-1:0] NULL_ENTRY = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } scan_state_e;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Working slot registers (indexed write, bulk clear) and the output copy that
// the compositor reads; commit copies the working slots including any same-cycle write.
module sprite_slot_bank #(
  parameter int ENTRY_W = 18,
  parameter int SLOTS   = 4,
  parameter int IW      = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [IW-1:0]              wr_idx_i,
  input  logic [ENTRY_W-1:0]         wr_dat_i,
  input  logic                       commit_i,
  output logic [SLOTS*ENTRY_W-1:0]   slots_o
);

  logic [ENTRY_W-1:0]       wk_q [SLOTS];
  logic [ENTRY_W-1:0]       wk_d [SLOTS];
  logic [SLOTS*ENTRY_W-1:0] flat_d;
  logic [SLOTS*ENTRY_W-1:0] out_q;

  always_comb begin
    flat_d = '0;
    for (int k = 0; k < SLOTS; k++) begin
      wk_d[k] = wk_q[k];
      if (clr_i) begin
        wk_d[k] = '0;
      end else if (wr_en_i && (wr_idx_i == IW'(k))) begin
        wk_d[k] = wr_dat_i;
      end
      flat_d[k*ENTRY_W +: ENTRY_W] = wk_d[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        wk_q[k] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        wk_q[k] <= wk_d[k];
      end
      if (commit_i) begin
        out_q <= flat_d;
      end
    end
  end

  assign slots_o = out_q;

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite picker: walks the hit table top-down through a 1-cycle read
// port, keeps the first MAX_PER_LINE hits, flags overflow; done NUM_SPRITES+1 edges after start.
module sprite_line_scanner
  import vpu_sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = NUM_SPRITES_DEF,
  parameter int MAX_PER_LINE = MAX_PER_LINE_DEF,
  parameter int ENTRY_W      = ENTRY_W_DEF,
  parameter int OVF_CHECK    = 1,
  localparam int AW = $clog2(NUM_SPRITES),
  localparam int CW = $clog2(MAX_PER_LINE + 1),
  localparam int IW = idx_w(MAX_PER_LINE)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            rd_en,
  output logic [AW-1:0]                   rd_addr,
  input  logic [ENTRY_W-1:0]              rd_data,
  output logic [MAX_PER_LINE*ENTRY_W-1:0] slots_out,
  output logic [CW-1:0]                   count_out,
  output logic                            overflow_out,
  output logic                            busy,
  output logic                            done
);

  scan_state_e   state_q;
  logic [AW-1:0] addr_q;
  logic          rd_en_q;
  logic          pend_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] count_out_q;
  logic          ovf_out_q;

  logic          hit;
  logic          wr_en;
  logic          term;
  logic [IW-1:0] wr_idx;
  logic          clr;
  logic          commit;

  // pend_q marks that rd_data carries the entry requested in the previous cycle.
  always_comb begin
    hit   = pend_q && (rd_data != ENTRY_W'(NULL_ENTRY));
    wr_en = 1'b0;
    term  = 1'b0;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (hit) begin
      if (cnt_q < CW'(MAX_PER_LINE)) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if ((OVF_CHECK == 0) && (cnt_d == CW'(MAX_PER_LINE))) begin
          term = 1'b1;
        end
      end else begin
        ovf_d = 1'b1;
        term  = 1'b1;
      end
    end
  end

  assign wr_idx = IW'(MAX_PER_LINE - 1) - IW'(cnt_q);
  assign clr    = (state_q == ST_IDLE) && start;
  assign commit = ((state_q == ST_SCAN) && term) || (state_q == ST_DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_out_q <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= rd_en_q;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SCAN;
            addr_q  <= AW'(NUM_SPRITES - 1);
            rd_en_q <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          if (term) begin
            // The read issued this cycle is dropped by clearing pend_q.
            state_q     <= ST_IDLE;
            rd_en_q     <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            count_out_q <= cnt_d;
            ovf_out_q   <= ovf_d;
          end else if (addr_q == '0) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q - 1'b1;
          end
        end
        ST_DRAIN: begin
          cnt_q       <= cnt_d;
          ovf_q       <= ovf_d;
          state_q     <= ST_IDLE;
          pend_q      <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          count_out_q <= cnt_d;
          ovf_out_q   <= ovf_d;
        end
        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sprite_slot_bank #(
    .ENTRY_W (ENTRY_W),
    .SLOTS   (MAX_PER_LINE),
    .IW      (IW)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (clr),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_dat_i (rd_data),
    .commit_i (commit),
    .slots_o  (slots_out)
  );

  assign rd_en        = rd_en_q;
  assign rd_addr      = addr_q;
  assign count_out    = count_out_q;
  assign overflow_out = ovf_out_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Scoreboard bench: directed tables push expected line results; per-instance monitors compare on done.
module tb_sprite_line_scanner;

  localparam int N = 32;
  localparam int M = 4;
  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           start_a, start_b;
  logic           rd_en_a, rd_en_b;
  logic [4:0]     addr_a, addr_b;
  logic [W-1:0]   rdat_a = '0;
  logic [W-1:0]   rdat_b = '0;
  logic [M*W-1:0] slots_a, slots_b;
  logic [2:0]     cnt_a, cnt_b;
  logic           ovf_a, ovf_b, busy_a, busy_b, done_a, done_b;

  logic [W-1:0] mem [N];

  sprite_line_scanner #(.NUM_SPRITES(N), .MAX_PER_LINE(M), .ENTRY_W(W), .OVF_CHECK(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .rd_en(rd_en_a), .rd_addr(addr_a),
    .rd_data(rdat_a), .slots_out(slots_a), .count_out(cnt_a), .overflow_out(ovf_a),
    .busy(busy_a), .done(done_a));

  sprite_line_scanner #(.NUM_SPRITES(N), .MAX_PER_LINE(M), .ENTRY_W(W), .OVF_CHECK(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .rd_en(rd_en_b), .rd_addr(addr_b),
    .rd_data(rdat_b), .slots_out(slots_b), .count_out(cnt_b), .overflow_out(ovf_b),
    .busy(busy_b), .done(done_b));

  // Table memory with one cycle of read latency per port.
  always @(posedge clk) begin
    if (rd_en_a) rdat_a <= mem[addr_a];
    if (rd_en_b) rdat_b <= mem[addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [M*W-1:0] slots;
    int             cnt;
    bit             ovf;
    int             acc;
    int             lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int total = 0;
  int bad   = 0;

  int rden_cnt_a = 0;
  int last_addr_a = 0;
  int min_addr_b = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [M*W-1:0] pack4(input logic [W-1:0] s3, input logic [W-1:0] s2,
                                           input logic [W-1:0] s1, input logic [W-1:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  always @(negedge clk) begin
    if (rd_en_a === 1'b1) begin
      rden_cnt_a++;
      last_addr_a = int'(addr_a);
    end
    if ((rd_en_b === 1'b1) && (int'(addr_b) < min_addr_b)) min_addr_b = int'(addr_b);
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_slots", slots_a, e.slots);
        check("a_count", cnt_a, e.cnt);
        check("a_overflow", ovf_a, e.ovf);
        check("a_latency", cyc - e.acc, e.lat);
        check("a_busy_in_done", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_slots", slots_b, e.slots);
        check("b_count", cnt_b, e.cnt);
        check("b_overflow", ovf_b, e.ovf);
        check("b_latency", cyc - e.acc, e.lat);
        check("b_busy_in_done", busy_b, 0);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic set_tbl_two_to_five();
    clear_mem();
    mem[31] = 18'h00011;
    mem[20] = 18'h00022;
    mem[5]  = 18'h00033;
  endtask

  task automatic set_tbl_ovf();
    clear_mem();
    mem[30] = 18'h00101;
    mem[25] = 18'h00202;
    mem[10] = 18'h00303;
    mem[3]  = 18'h00404;
    mem[1]  = 18'h00505;
  endtask

  // Called at a negedge; start is sampled by the following posedge.
  task automatic issue(input bit which, input logic [M*W-1:0] s, input int c, input bit o,
                       input int lat);
    exp_t e;
    e.slots = s;
    e.cnt   = c;
    e.ovf   = o;
    e.acc   = cyc + 1;
    e.lat   = lat;
    if (which) begin
      q_b.push_back(e);
      start_b = 1'b1;
    end else begin
      q_a.push_back(e);
      start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit which, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) got = 1'b1;
    end
    if (!got) check({nm, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    logic [M*W-1:0] t2_slots;
    logic [M*W-1:0] ovf_slots;
    t2_slots  = pack4(18'h00011, 18'h00022, 18'h00033, 18'h0);
    ovf_slots = pack4(18'h00101, 18'h00202, 18'h00303, 18'h00404);

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_slots_a", slots_a, 0);
    check("rst_count_a", cnt_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_rden_a", rd_en_a, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_slots_b", slots_b, 0);
    check("rst_busy_b", busy_b, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty table: full scan, nothing found.
    rden_cnt_a = 0;
    issue(0, '0, 0, 0, 33);
    wait_done(0, "t1");
    check("t1_rden_cycles", rden_cnt_a, 32);
    @(negedge clk);

    // Three hits, fewer than the slot count.
    set_tbl_two_to_five();
    issue(0, t2_slots, 3, 0, 33);
    wait_done(0, "t2");
    @(negedge clk);

    // Five hits with overflow detection: stops on entry 1.
    set_tbl_ovf();
    last_addr_a = 31;
    issue(0, ovf_slots, 4, 1, 32);
    wait_done(0, "t3");
    check("t3_last_rd_addr", last_addr_a, 0);
    @(negedge clk);

    // Same table without overflow detection: stops once entry 3 fills the slots.
    min_addr_b = 31;
    issue(1, ovf_slots, 4, 0, 30);
    wait_done(1, "t4");
    check("t4_min_rd_addr", min_addr_b, 2);
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle is accepted.
    set_tbl_two_to_five();
    issue(0, t2_slots, 3, 0, 33);
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, "t5a");
    clear_mem();
    mem[31] = 18'h00AAA;
    mem[0]  = 18'h3FFFF;
    issue(0, pack4(18'h00AAA, 18'h3FFFF, 18'h0, 18'h0), 2, 0, 33);
    repeat (10) @(negedge clk);
    check("t5_busy_second", busy_a, 1);
    check("t5_hold_slots", slots_a, t2_slots);
    check("t5_hold_count", cnt_a, 3);
    wait_done(0, "t5b");
    @(negedge clk);

    // Reset in the middle of a scan, then a clean full scan.
    set_tbl_ovf();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_slots", slots_a, 0);
    check("t6_rst_count", cnt_a, 0);
    check("t6_rst_ovf", ovf_a, 0);
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_rden", rd_en_a, 0);
    check("t6_rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_idle_rden", rd_en_a, 0);
    issue(0, ovf_slots, 4, 1, 32);
    wait_done(0, "t6");
    repeat (3) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_scanner.md
# sprite_line_scanner

Sequential, parametrised successor of the VPU's combinational top-4 sprite picker. Once per scanline, on a `start` pulse, it walks the sprite hit table from the highest index down to 0 via a 1-cycle-latency read port. It collects up to MAX_PER_LINE non-zero entries in priority order and reports an overflow when more hits exist than slots. Results are double-buffered so the compositor reads stable slots while the next line is being scanned.

## Interface
- NUM_SPRITES, 32: number of table entries scanned (≥2).
- MAX_PER_LINE, 4: number of output slots (1..NUM_SPRITES).
- ENTRY_W, 18: entry width; an all-zero entry means "no hit".
- OVF_CHECK, 1: 1 = keep scanning after the slots fill, to detect overflow; 0 = stop as soon as the slots fill.
- clk  in  1  single clock; all state is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to scan a line; honoured only when busy=0.
- rd_en  out  1  table read strobe.
- rd_addr  out  clog2(NUM_SPRITES)  table index.
- rd_data  in  ENTRY_W  entry for the address issued on the previous cycle.
- slots_out  out  MAX_PER_LINE*ENTRY_W  slot k occupies bits [k*ENTRY_W +: ENTRY_W]. Slot MAX_PER_LINE-1 holds the highest priority.
- count_out  out  clog2(MAX_PER_LINE+1)  number of valid slots.
- overflow_out  out  1  more than MAX_PER_LINE hits were found on the last line.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the slot, count and overflow outputs update.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- IDLE:
  - start=1 → clear the working buffer and hit counter, go to SCAN.
  - start while busy=1 is ignored.
- SCAN:
  - Issue rd_en=1 with rd_addr = NUM_SPRITES-1, then decrement by 1 per cycle down to 0.
  - After address 0 is issued, go to DRAIN.
- Evaluation of each returned rd_data (in SCAN and DRAIN):
  - Zero entry → skipped.
  - Non-zero entry while count < MAX_PER_LINE → written to working slot MAX_PER_LINE-1-count; count increments.
  - Non-zero entry while count = MAX_PER_LINE → overflow set; scan terminates early.
- Early termination, on overflow, or on the slots filling when OVF_CHECK=0:
  - Stop issuing reads.
  - Discard the read still in flight.
  - Go to IDLE and pulse done.
- DRAIN: evaluate the final return, then go to IDLE and pulse done.
- On done:
  - Working slots copy to slots_out.
  - Unfilled slots read 0.
  - count_out and overflow_out update atomically.
  - Outputs then hold until the next done.
- Width rule: count saturates at MAX_PER_LINE; no wrap.

## Timing
- Reset values: all outputs 0; FSM in IDLE. Reset mid-scan aborts immediately; no done pulse is produced.
- Start accepted at edge E0:
  - rd_en is high for cycles E0..E0+NUM_SPRITES-1.
  - Data for address NUM_SPRITES-1-k is evaluated at edge E0+k+2.
- Full-scan latency: done is high in the cycle after edge E0+NUM_SPRITES+1, with outputs valid in that same cycle.
- Early exit: done follows the edge that evaluated the terminating entry.
- busy is 1 from the cycle after E0 until the edge that raises done. busy=0 during the done cycle, so a start in that cycle is accepted (back-to-back lines).
- rd_data is sampled only in the cycle after rd_en=1; it is a don't-care otherwise.

## Structure
- Shared package `vpu_sprite_pkg` holds:
  - ENTRY_W default and the NULL_ENTRY constant (all zeros);
  - the FSM state enum;
  - the clog2 helper constants.
- One natural sub-module, `sprite_slot_bank`:
  - working and output slot registers with indexed write and clear;
  - a commit strobe that copies the working slots to the outputs.
- The scanner FSM, address counter and hit counter live in the top.

## Test plan
All scenarios use NUM_SPRITES=32, MAX_PER_LINE=4.
- Empty table, start → done 33 edges after the accept edge; slots_out=0, count_out=0, overflow_out=0.
- Entries 31=0x00011, 20=0x00022, 5=0x00033, OVF_CHECK=1 → slot3=0x00011, slot2=0x00022, slot1=0x00033, slot0=0; count=3; overflow=0.
- Non-zero entries at 30,25,10,3,1, OVF_CHECK=1 → slot3..slot0 = entries 30,25,10,3; count=4; overflow=1; done right after entry 1 is evaluated; last rd_addr issued=0.
- Same table with OVF_CHECK=0 → count=4; overflow=0; done immediately after entry 3 is evaluated; rd_addr never goes below 2.
- start pulsed while busy, then start in the done cycle → first pulse ignored; second scan starts; the previous results stay on slots_out until the new done.
- reset_n low at scan cycle 10 → all outputs 0; no done; rd_en low; next start runs a full, correct scan.
